// File: rtl/pll_dlf_pkg.sv
// Shared types and helpers for the PLL digital loop filter / lock controller.
package pll_dlf_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE        = 2'd0,
        FREQ_ACQ    = 2'd1,
        PHASE_TRACK = 2'd2,
        LOCKED      = 2'd3
    } state_e;

    // Clamp a signed value into the unsigned range [0, 2^width-1].
    function automatic longint unsigned sat_u(input longint val, input int unsigned width);
        longint          hi;
        longint unsigned res;
        hi = (longint'(1) <<< width) - longint'(1);
        if (val < longint'(0))
            res = '0;
        else if (val > hi)
            res = $unsigned(hi);
        else
            res = $unsigned(val);
        return res;
    endfunction

endpackage

// File: rtl/pll_dlf_ctrl_if.sv
// Error-sample / control-word bundle of pll_dlf_ctrl.
// lock_lost is present only when PLL_LOCK_LOSS_DETECT_EN is defined.
interface pll_dlf_ctrl_if #(
    parameter int ERR_W = 12,
    parameter int CW_W  = 16
);
    import pll_dlf_pkg::*;

    logic               err_valid;
    logic [ERR_W-1:0]   err;
    logic [CW_W-1:0]    cw;
    logic               cw_valid;
    logic               lock;
    logic [STATE_W-1:0] state;

`ifdef PLL_LOCK_LOSS_DETECT_EN
    logic               lock_lost;

    modport master (output err_valid, err, input cw, cw_valid, lock, state, lock_lost);
    modport slave  (input err_valid, err, output cw, cw_valid, lock, state, lock_lost);
`else
    modport master (output err_valid, err, input cw, cw_valid, lock, state);
    modport slave  (input err_valid, err, output cw, cw_valid, lock, state);
`endif

endinterface

// File: rtl/pll_lock_det.sv
// Lock qualification: consecutive in-tolerance counter and, with
// PLL_LOCK_LOSS_DETECT_EN, the two-strike loss detector with sticky flag.
module pll_lock_det #(
    parameter int ERR_W          = 12,
    parameter int ERR_TOL        = 4,
    parameter int LOCK_COUNT_MAX = 10
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample,
    input  logic             trk_en,
    input  logic [ERR_W-1:0] err,
`ifdef PLL_LOCK_LOSS_DETECT_EN
    input  logic             lkd_en,
    input  logic             idle,
    output logic             loss_hit,
    output logic             lock_lost,
`endif
    output logic             lock_hit
);
    localparam int LC_W = $clog2(LOCK_COUNT_MAX + 1);
    localparam logic [LC_W-1:0]         LC_LAST = LC_W'(LOCK_COUNT_MAX - 1);
    localparam logic signed [ERR_W-1:0] TOL     = ERR_W'(ERR_TOL);

    logic signed [ERR_W-1:0] err_s;
    logic                    in_tol;
    logic [LC_W-1:0]         lock_cnt;

    // The most-negative code lies below -TOL, so it is out of tolerance naturally.
    assign err_s    = $signed(err);
    assign in_tol   = (err_s >= -TOL) && (err_s <= TOL);
    assign lock_hit = trk_en && sample && in_tol && (lock_cnt == LC_LAST);

    // NOTE: flops are written with <= so every reader sees the pre-edge value.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n)
            lock_cnt <= '0;
        else if (clr || !trk_en)
            lock_cnt <= '0;
        else if (sample)
            lock_cnt <= in_tol ? lock_cnt + 1'b1 : '0;
    end

`ifdef PLL_LOCK_LOSS_DETECT_EN
    localparam logic signed [ERR_W-1:0] BIG = ERR_W'(4 * ERR_TOL);

    logic big;
    logic loss_armed;

    assign big      = (err_s > BIG) || (err_s < -BIG);
    assign loss_hit = lkd_en && sample && big && loss_armed;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_armed <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            if (clr || !lkd_en)
                loss_armed <= 1'b0;
            else if (sample)
                loss_armed <= big;

            if (idle)
                lock_lost <= 1'b0;
            else if (loss_hit)
                lock_lost <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/pll_dlf_ctrl.sv
// PLL digital loop filter (saturating PI) and acquisition/track/lock sequencer on rclk.
// Defining PLL_LOCK_LOSS_DETECT_EN adds lock-loss detection and the lock_lost flag.
module pll_dlf_ctrl
    import pll_dlf_pkg::*;
#(
    parameter int              FBDIV_W        = 10,
    parameter int              ERR_W          = 12,
    parameter int              CW_W           = 16,
    parameter int              FRAC_W         = 8,
    parameter logic [CW_W-1:0] CW_INIT        = 16'h8000,
    parameter int              KP_SHIFT       = 3,
    parameter int              KI_SHIFT       = 7,
    parameter int              KI_ACQ_SHIFT   = 3,
    parameter int              ACQ_SAMPLES    = 256,
    parameter int              ERR_TOL        = 4,
    parameter int              LOCK_COUNT_MAX = 10
) (
    input  logic               rclk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [FBDIV_W-1:0] fbdiv,
    input  logic               skip_phase_lock,
    pll_dlf_ctrl_if.slave      bus
);
    localparam int INT_W = CW_W + FRAC_W;
    localparam int INC_W = ERR_W + FRAC_W;
    localparam int ACQ_W = $clog2(ACQ_SAMPLES + 1);
    localparam logic [INT_W-1:0] INTEG_INIT = {CW_INIT, {FRAC_W{1'b0}}};
    localparam logic [ACQ_W-1:0] ACQ_LAST   = ACQ_W'(ACQ_SAMPLES - 1);

    state_e                  state_q, state_d;
    logic [FBDIV_W-1:0]      fbdiv_q;
    logic [INT_W-1:0]        integ_q, integ_d, integ_new;
    logic [CW_W-1:0]         cw_q, cw_d, cw_new;
    logic                    cw_valid_q, cw_valid_d;
    logic [ACQ_W-1:0]        acq_cnt_q, acq_cnt_d;
    logic signed [ERR_W-1:0] err_s, p_term;
    logic signed [INC_W-1:0] err_sc, inc;
    logic                    fb_change, sample, clr, lock_hit;
`ifdef PLL_LOCK_LOSS_DETECT_EN
    logic                    loss_hit;
`endif

    // A divider change outranks the sample: that cycle's err is dropped.
    assign fb_change = (state_q != IDLE) && (fbdiv != fbdiv_q);
    assign sample    = en && (state_q != IDLE) && !fb_change && bus.err_valid;
    assign clr       = !en || fb_change;

    always_comb begin
        err_s  = $signed(bus.err);
        err_sc = $signed({bus.err, {FRAC_W{1'b0}}});
        if (state_q == FREQ_ACQ) begin
            inc    = err_sc >>> KI_ACQ_SHIFT;
            p_term = '0;
        end else begin
            inc    = err_sc >>> KI_SHIFT;
            p_term = err_s >>> KP_SHIFT;
        end
        integ_new = INT_W'(sat_u(longint'(integ_q) + longint'(inc), INT_W));
        cw_new    = CW_W'(sat_u(longint'(integ_new[INT_W-1:FRAC_W]) + longint'(p_term), CW_W));
    end

    pll_lock_det #(
        .ERR_W          (ERR_W),
        .ERR_TOL        (ERR_TOL),
        .LOCK_COUNT_MAX (LOCK_COUNT_MAX)
    ) u_lock_det (
        .rclk      (rclk),
        .rst_n     (rst_n),
        .clr       (clr),
        .sample    (sample),
        .trk_en    (state_q == PHASE_TRACK),
        .err       (bus.err),
`ifdef PLL_LOCK_LOSS_DETECT_EN
        .lkd_en    (state_q == LOCKED),
        .idle      (state_q == IDLE),
        .loss_hit  (loss_hit),
        .lock_lost (bus.lock_lost),
`endif
        .lock_hit  (lock_hit)
    );

    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        integ_d    = integ_q;
        cw_d       = cw_q;
        cw_valid_d = 1'b0;
        acq_cnt_d  = acq_cnt_q;
        if (!en) begin
            state_d   = IDLE;
            integ_d   = INTEG_INIT;
            cw_d      = CW_INIT;
            acq_cnt_d = '0;
        end else if (state_q == IDLE) begin
            if (fbdiv != '0)
                state_d = FREQ_ACQ;
        end else if (fb_change) begin
            state_d   = FREQ_ACQ;
            acq_cnt_d = '0;
        end else if (sample) begin
            integ_d    = integ_new;
            cw_d       = cw_new;
            cw_valid_d = 1'b1;
            unique case (state_q)
                FREQ_ACQ: begin
                    if (acq_cnt_q == ACQ_LAST) begin
                        acq_cnt_d = '0;
                        state_d   = skip_phase_lock ? LOCKED : PHASE_TRACK;
                    end else begin
                        acq_cnt_d = acq_cnt_q + 1'b1;
                    end
                end
                PHASE_TRACK: if (lock_hit) state_d = LOCKED;
`ifdef PLL_LOCK_LOSS_DETECT_EN
                LOCKED:      if (loss_hit) state_d = PHASE_TRACK;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fbdiv_q    <= '0;
            integ_q    <= INTEG_INIT;
            cw_q       <= CW_INIT;
            cw_valid_q <= 1'b0;
            acq_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            integ_q    <= integ_d;
            cw_q       <= cw_d;
            cw_valid_q <= cw_valid_d;
            acq_cnt_q  <= acq_cnt_d;
            if (state_q == IDLE || fb_change)
                fbdiv_q <= fbdiv;
        end
    end

    assign bus.cw       = cw_q;
    assign bus.cw_valid = cw_valid_q;
    assign bus.lock     = (state_q == LOCKED);
    assign bus.state    = state_q;

endmodule

// File: doc/pll_dlf_ctrl.md
Name: pll_dlf_ctrl

Overview:
- Digital loop-filter and lock controller for the next-generation PLL core. Runs on the reference clock.
- Consumes signed TDC phase-error samples and produces a saturating DCO control word.
- Sequences frequency acquisition, phase tracking and lock declaration.
- Generalises the fixed 8-bit-divider model: parametrised divider width, error/control widths, PI gains and lock criteria.

Parameters:
- FBDIV_W, 10, feedback divider width in bits.
- ERR_W, 12, signed TDC error width in bits.
- CW_W, 16, unsigned DCO control word width in bits.
- FRAC_W, 8, integrator fractional bits.
- CW_INIT, 16'h8000, control word loaded in IDLE.
- KP_SHIFT, 3, proportional gain = 2^-KP_SHIFT.
- KI_SHIFT, 7, tracking integral gain = 2^-KI_SHIFT.
- KI_ACQ_SHIFT, 3, acquisition integral gain = 2^-KI_ACQ_SHIFT.
- ACQ_SAMPLES, 256, number of valid error samples spent in FREQ_ACQ.
- ERR_TOL, 4, lock tolerance: |err| <= ERR_TOL counts as in-lock.
- LOCK_COUNT_MAX, 10, consecutive in-tolerance samples required to assert lock.

Ports:
- rclk  input  1  reference clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  loop enable; low forces IDLE.
- fbdiv  input  FBDIV_W  feedback divide ratio; 0 is invalid.
- skip_phase_lock  input  1  declare lock straight after acquisition.
- err_valid  input  1  err sample qualifier, one cycle per sample.
- err  input  ERR_W  signed two's-complement phase error.
- cw  output  CW_W  DCO control word.
- cw_valid  output  1  one-cycle pulse when cw updates.
- lock  output  1  lock indicator.
- state  output  2  FSM state: 0 IDLE, 1 FREQ_ACQ, 2 PHASE_TRACK, 3 LOCKED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cw = CW_INIT, integrator = CW_INIT << FRAC_W.
  - cw_valid = 0, lock = 0, state = IDLE, all counters 0.
- IDLE: holds reset values. Exits to FREQ_ACQ when en = 1 and fbdiv != 0.
- fbdiv is registered on leaving IDLE. Any later change of fbdiv against the registered copy, while not in IDLE:
  - lock drops next cycle.
  - integrator is kept.
  - counters clear.
  - state goes to FREQ_ACQ.
- en low in any state: IDLE next cycle with reset values, except rst_n-only behaviour does not apply.
- Sample update: on each rclk edge with err_valid = 1 in FREQ_ACQ, PHASE_TRACK or LOCKED:
  - e = sign-extend(err).
  - integ += (e << FRAC_W) >>> KI (arithmetic shift). KI = KI_ACQ_SHIFT in FREQ_ACQ, else KI_SHIFT.
  - cw = sat(integ >> FRAC_W + (e >>> KP_SHIFT)), using the updated integ. In FREQ_ACQ the proportional term is 0.
  - sat clamps to [0, 2^CW_W-1]. The integrator also clamps to the same range scaled by 2^FRAC_W; no wrap-around.
  - Latency: cw and cw_valid registered 1 cycle after the err_valid edge. cw_valid is 0 otherwise.
- err_valid in IDLE: ignored.
- FREQ_ACQ: counts valid samples. After ACQ_SAMPLES:
  - skip_phase_lock = 1 -> LOCKED.
  - otherwise -> PHASE_TRACK.
- PHASE_TRACK:
  - In-tolerance sample (|err| <= ERR_TOL; |most-negative| treated as out-of-tolerance): lock_cnt increments.
  - Any out-of-tolerance sample clears lock_cnt.
  - When lock_cnt reaches LOCK_COUNT_MAX: LOCKED, and lock = 1 in the same cycle state shows LOCKED.
- LOCKED: loop keeps tracking with KP/KI. lock = 1 exactly when state = LOCKED.
- Simultaneous events, priority high to low: rst_n, en low, fbdiv change, sample update. The fbdiv-change cycle discards err.

Optional Feature:
- Macro: PLL_LOCK_LOSS_DETECT_EN.
- Defined: in LOCKED, two consecutive valid samples with |err| > 4*ERR_TOL drop lock. The FSM returns to PHASE_TRACK with lock_cnt = 0. A sticky output port lock_lost (1 bit) sets and stays set until IDLE.
- Undefined: LOCKED is held until en, fbdiv or rst_n changes. Port lock_lost is absent.

Decomposition:
- Package pll_dlf_pkg:
  - state_e enum (IDLE, FREQ_ACQ, PHASE_TRACK, LOCKED; 2-bit).
  - STATE_W constant.
  - Saturate function parametrised by width.
- Sub-module pll_lock_det:
  - Takes err_valid, err and the state enables.
  - Outputs lock_hit (lock_cnt reached LOCK_COUNT_MAX) and, when the feature is defined, lock_lost.
  - Owns lock_cnt and the loss counter.
- Top pll_dlf_ctrl holds the FSM, integrator and cw datapath.

Test Plan:
- Reset with en = 1, fbdiv = 10: during rst_n low, cw = 16'h8000, lock = 0, state = 0. On release, state = 1 next edge.
- Defaults, err = +64 on every valid sample in FREQ_ACQ: integ grows by 8 per sample, and cw increments by 8 each sample, 1 cycle after err_valid. After 256 samples, state = 2.
- PHASE_TRACK, 9 samples err = 3, then err = 5, then 10 samples err = -4: lock stays 0 through the first 10 samples. lock = 1 and state = 3 after the 20th sample.
- In LOCKED, change fbdiv 10 -> 12: lock = 0 and state = 1 next cycle. cw is unchanged on that cycle.
- Integrator saturation, err = 2047 held: cw clamps at 16'hFFFF with no wrap. Then err = -2048: cw clamps at 0.
- PLL_LOCK_LOSS_DETECT_EN defined, in LOCKED, err = 17, 17: lock = 0, lock_lost = 1, state = 2. A single err = 17 followed by err = 0 keeps lock = 1.
